// File: rtl/accel_dma.sv
// ---------------------------------------------------------------------------
// accel_dma
//
// Single-channel word DMA between a local RAM and an accelerator MMIO window.
// One command moves cmd_len 32-bit words in either direction:
//   dir 0 : RAM -> accelerator  (RAM_RD, RAM_CAP, ACC_WR per word)
//   dir 1 : accelerator -> RAM  (ACC_RD, RAM_WR per word)
// Commands are validated at acceptance. A bad command raises the sticky err
// flag and finishes without touching either bus.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; cmd_ready is high only when idle
//   cmd_dir             : 0 = RAM to accelerator, 1 = accelerator to RAM
//   cmd_ram_addr        : RAM byte address (must be word aligned)
//   cmd_acc_off         : accelerator byte offset (must be word aligned)
//   cmd_len             : number of words to move (non-zero)
//   abort               : stop request; the transfer ends early and sets err
//   busy, done, err     : status; done is a one-cycle completion pulse
//   ram_*               : RAM port, read data returned the cycle after ram_req
//   acc_*               : accelerator valid/ready port, 32-bit word accesses
// ---------------------------------------------------------------------------
module accel_dma #(
    parameter int unsigned RAM_AW     = 12,
    parameter logic [31:0] ACCEL_BASE = 32'h0200_0000
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [31:0]       cmd_ram_addr,
    input  logic [7:0]        cmd_acc_off,
    input  logic [15:0]       cmd_len,
    input  logic              abort,

    output logic              busy,
    output logic              done,
    output logic              err,

    output logic              ram_req,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,

    output logic              acc_valid,
    output logic              acc_write,
    output logic [31:0]       acc_addr,
    output logic [31:0]       acc_wdata,
    output logic [3:0]        acc_wstrb,
    input  logic [31:0]       acc_rdata,
    input  logic              acc_ready
);

    typedef enum logic [2:0] {
        IDLE,
        RAM_RD,
        RAM_CAP,
        ACC_WR,
        ACC_RD,
        RAM_WR,
        DONE
    } state_t;

    // Number of words in the RAM, one bit wider than the largest end index.
    localparam logic [32:0] RAM_WORDS = 33'd1 << RAM_AW;

    state_t            state_q;
    state_t            state_d;

    logic [RAM_AW-1:0] ram_base_q;
    logic [7:0]        acc_off_q;
    logic [15:0]       len_q;
    logic [15:0]       pos_q;
    logic [31:0]       data_q;
    logic              err_q;
    logic              abort_q;

    logic              load_cmd;
    logic              set_err;
    logic              clr_err;
    logic              cap_ram;
    logic              cap_acc;
    logic              word_adv;
    logic              abort_d;

    logic [32:0]       ram_end;
    logic [18:0]       acc_end;
    logic              cmd_bad;

    logic [RAM_AW-1:0] ram_word;
    logic [7:0]        acc_byte;
    logic              last_word;

    // Command validation, evaluated on the raw inputs so the decision is
    // ready in the acceptance cycle. Sums are widened so they cannot wrap.
    always_comb begin
        ram_end = {3'b000, cmd_ram_addr[31:2]} + {17'd0, cmd_len};
        acc_end = {11'd0, cmd_acc_off} + {1'b0, cmd_len, 2'b00};
        cmd_bad = (cmd_len == 16'd0)
               || (cmd_ram_addr[1:0] != 2'b00)
               || (ram_end > RAM_WORDS)
               || (cmd_acc_off[1:0] != 2'b00)
               || (acc_end > 19'd256);
    end

    // Current word addresses. The range check guarantees the accelerator
    // offset stays inside the 256-byte window, so 8 bits are enough and the
    // low six bits of pos cover every legal word.
    always_comb begin
        ram_word  = ram_base_q + RAM_AW'(pos_q);
        acc_byte  = acc_off_q + {pos_q[5:0], 2'b00};
        last_word = ((pos_q + 16'd1) == len_q);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. Bus outputs are zero outside the state
    // that owns them, which keeps ram_req and acc_valid mutually exclusive.
    // An abort seen while an accelerator handshake is pending is remembered
    // in abort_q so a one-cycle abort pulse still ends the transfer once
    // the handshake completes.
    always_comb begin
        state_d   = state_q;
        load_cmd  = 1'b0;
        set_err   = 1'b0;
        clr_err   = 1'b0;
        cap_ram   = 1'b0;
        cap_acc   = 1'b0;
        word_adv  = 1'b0;
        abort_d   = 1'b0;

        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;

        acc_valid = 1'b0;
        acc_write = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        acc_wstrb = 4'h0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    load_cmd = 1'b1;
                    if (cmd_bad) begin
                        set_err = 1'b1;
                        state_d = DONE;
                    end else begin
                        clr_err = 1'b1;
                        state_d = cmd_dir ? ACC_RD : RAM_RD;
                    end
                end
            end

            RAM_RD: begin
                ram_req  = 1'b1;
                ram_addr = ram_word;
                if (abort) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RAM_CAP;
                end
            end

            RAM_CAP: begin
                cap_ram = 1'b1;
                if (abort) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = ACC_WR;
                end
            end

            ACC_WR: begin
                acc_valid = 1'b1;
                acc_write = 1'b1;
                acc_addr  = ACCEL_BASE | {24'd0, acc_byte};
                acc_wdata = data_q;
                acc_wstrb = 4'hF;
                if (abort) begin
                    set_err = 1'b1;
                end
                if (acc_ready) begin
                    word_adv = 1'b1;
                    if (abort || abort_q || last_word) begin
                        state_d = DONE;
                    end else begin
                        state_d = RAM_RD;
                    end
                end else begin
                    abort_d = abort_q || abort;
                end
            end

            ACC_RD: begin
                acc_valid = 1'b1;
                acc_addr  = ACCEL_BASE | {24'd0, acc_byte};
                if (abort) begin
                    set_err = 1'b1;
                end
                if (acc_ready) begin
                    cap_acc = 1'b1;
                    if (abort || abort_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = RAM_WR;
                    end
                end else begin
                    abort_d = abort_q || abort;
                end
            end

            RAM_WR: begin
                ram_req   = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = ram_word;
                ram_wdata = data_q;
                word_adv  = 1'b1;
                if (abort) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end else if (last_word) begin
                    state_d = DONE;
                end else begin
                    state_d = ACC_RD;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: latched command, word position, data holding register and
    // the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_base_q <= '0;
            acc_off_q  <= 8'd0;
            len_q      <= 16'd0;
            pos_q      <= 16'd0;
            data_q     <= 32'd0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            if (load_cmd) begin
                ram_base_q <= RAM_AW'(cmd_ram_addr[31:2]);
                acc_off_q  <= cmd_acc_off;
                len_q      <= cmd_len;
                pos_q      <= 16'd0;
            end else if (word_adv) begin
                pos_q <= pos_q + 16'd1;
            end

            if (cap_ram) begin
                data_q <= ram_rdata;
            end else if (cap_acc) begin
                data_q <= acc_rdata;
            end

            if (set_err) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end

            abort_q <= abort_d;
        end
    end

    assign err = err_q;

endmodule
